// File: rtl/main_control_sequencer.sv
// main_control_sequencer: run/step/stop sequencer and opcode decoder driving the
// control inputs of a single-cycle datapath, with halt/illegal detection and
// saturating retired / taken-branch counters.
module main_control_sequencer #(
    parameter int unsigned EXEC_CYCLES = 2,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stepMode,
    input  logic                   step,
    input  logic                   stop,
    input  logic [5:0]             OpCode,
    input  logic                   isZero,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic [1:0]             ALUOp,
    output logic                   ALUSrc,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   Branch,
    output logic                   Jump,
    output logic                   updatePC,
    output logic                   running,
    output logic                   halted,
    output logic                   illegalOp,
    output logic [COUNT_WIDTH-1:0] retiredCount,
    output logic [COUNT_WIDTH-1:0] takenCount
);

    localparam int unsigned PHASE_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_STEP,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    state_t                 state_q;
    logic [PHASE_W-1:0]     phase_q;
    logic                   stop_q;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic [COUNT_WIDTH-1:0] taken_q, taken_d;

    logic       is_halt, dec_known, dec_legal;
    logic       dec_regdst, dec_alusrc, dec_memtoreg, dec_regwrite;
    logic       dec_memread, dec_memwrite, dec_branch, dec_jump;
    logic [1:0] dec_aluop;
    logic       in_exec, first_phase, last_phase, abort, commit, stop_seen;

    // Opcode decode; the halt opcode and unknown opcodes decode to all zeros
    always_comb begin
        dec_known    = 1'b1;
        dec_regdst   = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_aluop    = 2'b00;
        is_halt      = (OpCode == HALT_OPCODE);
        case (OpCode)
            6'h00: begin dec_regdst = 1'b1; dec_regwrite = 1'b1; dec_aluop = 2'b10; end
            6'h23: begin dec_alusrc = 1'b1; dec_memtoreg = 1'b1; dec_regwrite = 1'b1; dec_memread = 1'b1; end
            6'h2B: begin dec_alusrc = 1'b1; dec_memwrite = 1'b1; end
            6'h08: begin dec_alusrc = 1'b1; dec_regwrite = 1'b1; end
            6'h04: begin dec_branch = 1'b1; dec_aluop = 2'b01; end
            6'h02: begin dec_jump = 1'b1; end
            default: dec_known = 1'b0;
        endcase
        if (is_halt) begin
            dec_known    = 1'b0;
            dec_regdst   = 1'b0;
            dec_alusrc   = 1'b0;
            dec_memtoreg = 1'b0;
            dec_regwrite = 1'b0;
            dec_memread  = 1'b0;
            dec_memwrite = 1'b0;
            dec_branch   = 1'b0;
            dec_jump     = 1'b0;
            dec_aluop    = 2'b00;
        end
        dec_legal = dec_known;
    end

    // Sequencing qualifiers; halt/illegal at phase 0 pre-empts a same-cycle commit
    always_comb begin
        in_exec     = (state_q == S_EXEC);
        first_phase = (phase_q == '0);
        last_phase  = (phase_q == LAST_PHASE);
        abort       = in_exec && first_phase && !dec_legal;
        commit      = in_exec && last_phase && !abort;
        stop_seen   = stop_q || stop;
    end

    // Saturating counter next values
    always_comb begin
        retired_d = retired_q;
        taken_d   = taken_q;
        if (commit && (retired_q != '1)) begin
            retired_d = retired_q + COUNT_WIDTH'(1);
        end
        if (commit && dec_branch && isZero && (taken_q != '1)) begin
            taken_d = taken_q + COUNT_WIDTH'(1);
        end
    end

    // Datapath controls: selects follow decode during EXEC, strobes only on commit
    always_comb begin
        RegDst       = in_exec && dec_regdst;
        ALUSrc       = in_exec && dec_alusrc;
        MemtoReg     = in_exec && dec_memtoreg;
        MemRead      = in_exec && dec_memread;
        Branch       = in_exec && dec_branch;
        Jump         = in_exec && dec_jump;
        ALUOp        = in_exec ? dec_aluop : 2'b00;
        RegWrite     = commit && dec_regwrite;
        MemWrite     = commit && dec_memwrite;
        updatePC     = commit && dec_legal;
        running      = in_exec;
        halted       = (state_q == S_HALT);
        illegalOp    = (state_q == S_ERROR);
        retiredCount = retired_q;
        takenCount   = taken_q;
    end

    // Sequencer state, phase counter, stop latch and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            stop_q    <= 1'b0;
            retired_q <= '0;
            taken_q   <= '0;
        end else begin
            retired_q <= retired_d;
            taken_q   <= taken_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= stepMode ? S_WAIT_STEP : S_EXEC;
                        phase_q <= '0;
                    end
                end
                S_WAIT_STEP: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        stop_q  <= 1'b0;
                    end else if (step) begin
                        state_q <= S_EXEC;
                        phase_q <= '0;
                    end
                end
                S_EXEC: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (abort) begin
                        state_q <= is_halt ? S_HALT : S_ERROR;
                    end else if (last_phase) begin
                        phase_q <= '0;
                        if (stop_seen) begin
                            state_q <= S_IDLE;
                            stop_q  <= 1'b0;
                        end else if (stepMode) begin
                            state_q <= S_WAIT_STEP;
                        end
                    end else begin
                        phase_q <= phase_q + PHASE_W'(1);
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_control_sequencer.sv
// Scoreboard bench for main_control_sequencer: stimulus pushes expected commits,
// a negedge monitor pops and compares whenever updatePC is seen.
module tb_main_control_sequencer;

    localparam int unsigned EC   = 2;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;
    localparam logic [9:0]  SEL_MASK = 10'b1_1_1_0_1_0_1_1_11;

    logic          clk = 1'b0;
    logic          rst, start, stepMode, step, stop, isZero;
    logic [5:0]    OpCode;
    logic          RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, Jump, updatePC;
    logic [1:0]    ALUOp;
    logic          running, halted, illegalOp;
    logic [CW-1:0] retiredCount, takenCount;

    typedef struct packed {
        logic [9:0]    ctrl;
        logic [CW-1:0] ret_before;
        logic [CW-1:0] tak_before;
    } exp_t;

    exp_t       expq[$];
    exp_t       mon_e;
    logic [9:0] mon_act;
    int         checks   = 0;
    int         failures = 0;
    int         exp_ret  = 0;
    int         exp_tak  = 0;
    bit         mon_en   = 1'b0;
    logic [5:0] legal_ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02};

    main_control_sequencer #(
        .EXEC_CYCLES (EC),
        .HALT_OPCODE (6'h3F),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stepMode     (stepMode),
        .step         (step),
        .stop         (stop),
        .OpCode       (OpCode),
        .isZero       (isZero),
        .RegDst       (RegDst),
        .RegWrite     (RegWrite),
        .ALUOp        (ALUOp),
        .ALUSrc       (ALUSrc),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .Branch       (Branch),
        .Jump         (Jump),
        .updatePC     (updatePC),
        .running      (running),
        .halted       (halted),
        .illegalOp    (illegalOp),
        .retiredCount (retiredCount),
        .takenCount   (takenCount)
    );

    always #5 clk = ~clk;

    // Reference decode: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp}
    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b1_0_0_1_0_0_0_0_10;
            6'h23:   return 10'b0_1_1_1_1_0_0_0_00;
            6'h2B:   return 10'b0_1_0_0_0_1_0_0_00;
            6'h08:   return 10'b0_1_0_1_0_0_0_0_00;
            6'h04:   return 10'b0_0_0_0_0_0_1_0_01;
            6'h02:   return 10'b0_0_0_0_0_0_0_1_00;
            default: return 10'b0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0;
        exp_ret = 0; exp_tak = 0;
        tick(); tick();
        rst = 1'b1;
    endtask

    // Present one instruction and record its expected commit, if it is legal
    task automatic issue(input logic [5:0] op, input logic z);
        exp_t e;
        OpCode = op;
        isZero = z;
        if (is_legal(op)) begin
            e.ctrl       = ref_ctrl(op);
            e.ret_before = CW'(exp_ret);
            e.tak_before = CW'(exp_tak);
            expq.push_back(e);
            exp_ret = (exp_ret < MAXC) ? exp_ret + 1 : MAXC;
            if (op == 6'h04 && z) exp_tak = (exp_tak < MAXC) ? exp_tak + 1 : MAXC;
        end
    endtask

    // One instruction in run mode; stop pulsed at phase stop_ph (-1 for none)
    task automatic instr(input logic [5:0] op, input logic z, input int stop_ph);
        issue(op, z);
        for (int p = 0; p < int'(EC); p++) begin
            stop = (p == stop_ph);
            tick();
        end
        stop = 1'b0;
    endtask

    task automatic begin_run(input logic sm);
        stepMode = sm;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic check_idle_counts(input string tag);
        @(negedge clk);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_retired"}, 32'(retiredCount), 32'(exp_ret));
        check({tag, "_taken"}, 32'(takenCount), 32'(exp_tak));
    endtask

    // Monitor: idle outputs zero, selects track decode, commits pop the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp};
            if (!running) begin
                check("not_running_zero", 32'({mon_act, updatePC}), 32'd0);
            end else begin
                check("select_vs_opcode", 32'(mon_act & SEL_MASK), 32'(ref_ctrl(OpCode) & SEL_MASK));
                if (updatePC) begin
                    if (expq.size() == 0) begin
                        check("unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        mon_e = expq.pop_front();
                        check("commit_ctrl", 32'(mon_act), 32'(mon_e.ctrl));
                        check("commit_retired", 32'(retiredCount), 32'(mon_e.ret_before));
                        check("commit_taken", 32'(takenCount), 32'(mon_e.tak_before));
                    end
                end else begin
                    check("strobes_off", 32'({RegWrite, MemWrite}), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stepMode = 1'b0; step = 1'b0; stop = 1'b0;
        OpCode = 6'h00; isZero = 1'b0;
        do_reset();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_retired", 32'(retiredCount), 32'd0);
        check("rst_taken", 32'(takenCount), 32'd0);
        check("rst_flags", 32'({running, halted, illegalOp}), 32'd0);

        // Three R-type instructions in run mode, stop during the last
        OpCode = 6'h00;
        begin_run(1'b0);
        instr(6'h00, 1'b0, -1);
        instr(6'h00, 1'b1, -1);
        instr(6'h00, 1'b0, 0);
        check_idle_counts("rtype");

        // lw then sw
        begin_run(1'b0);
        instr(6'h23, 1'b0, -1);
        instr(6'h2B, 1'b1, 1);
        check_idle_counts("lwsw");

        // beq taken then not taken
        begin_run(1'b0);
        instr(6'h04, 1'b1, -1);
        instr(6'h04, 1'b0, 0);
        check_idle_counts("beq");

        // Step mode: three spaced steps, idle between them
        begin_run(1'b1);
        for (int k = 0; k < 3; k++) begin
            issue(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (4) tick();
            @(negedge clk);
            check("step_gap_running", 32'(running), 32'd0);
        end
        stop = 1'b1; step = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        step = 1'b0;
        check_idle_counts("step");

        // Randomized runs; counters saturate along the way
        for (int r = 0; r < 4; r++) begin
            begin_run(1'b0);
            for (int k = 0; k < 6; k++) begin
                instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      (k == 5) ? int'($urandom_range(0, EC - 1)) : -1);
            end
            check_idle_counts("random");
        end
        check("sat_retired", 32'(retiredCount), 32'(MAXC));

        // Halt: no commit, sticky against start/step
        check("q_drained_pre_halt", 32'(expq.size()), 32'd0);
        do_reset();
        begin_run(1'b0);
        instr(6'h08, 1'b0, -1);
        OpCode = 6'h3F;
        tick();
        @(negedge clk);
        check("halted_set", 32'({halted, running, illegalOp}), 32'b100);
        start = 1'b1; step = 1'b1;
        repeat (3) tick();
        start = 1'b0; step = 1'b0;
        @(negedge clk);
        check("halted_sticky", 32'({halted, running}), 32'b10);
        check("halt_retired", 32'(retiredCount), 32'(exp_ret));

        // Illegal opcode
        do_reset();
        OpCode = 6'h11;
        begin_run(1'b0);
        tick();
        @(negedge clk);
        check("illegal_set", 32'({illegalOp, halted, running}), 32'b100);
        check("illegal_strobes", 32'({updatePC, RegWrite, MemWrite}), 32'd0);

        // Reset at phase 0 of a store: it never commits
        do_reset();
        OpCode = 6'h2B;
        begin_run(1'b0);
        do_reset();
        check_idle_counts("midreset");

        check("q_drained_end", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
